// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_AW        = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned WB_FIFO_DEPTH = 2;
  localparam int unsigned STARVE_LIM    = 7;
  localparam int unsigned STARVE_W      = $clog2(STARVE_LIM + 1);
  localparam int unsigned NUM_REGS      = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  // Owner of the single register-file write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Small synchronous FIFO holding long-latency writeback beats {addr, data}.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [REG_AW-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = mem_q[rd_ptr_q].addr;
  assign head_data = mem_q[rd_ptr_q].data;

  // Pointer, occupancy and storage updates; overflow/underflow requests are ignored.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = '{addr: push_addr, data: push_data};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // State register with synchronous reset discarding any held entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: ALU path (A) has fixed priority over a FIFO of long-latency
// results (B); a starvation counter throttles A, and a busy scoreboard tracks
// registers with long-latency results still outstanding.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_stall,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              hz_rs,
  output logic              hz_rt,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  grant_e              grant;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_AW-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;

  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                a_stall_q, a_stall_d;
  logic                err_a_q, err_a_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rf_wb_fifo #(
    .DEPTH(WB_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_addr(b_addr),
    .push_data(b_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_addr(head_addr),
    .head_data(head_data)
  );

  // b_ready follows pre-pop occupancy, so a full FIFO accepts nothing even when popping.
  assign b_ready   = !fifo_full;
  assign fifo_push = b_valid && !fifo_full;
  assign fifo_pop  = (grant == GNT_B);

  assign a_stall  = a_stall_q;
  assign busy_vec = busy_q;
  assign hz_rs    = (rs_addr != '0) && busy_q[rs_addr];
  assign hz_rt    = (rt_addr != '0) && busy_q[rt_addr];
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Port grant: A unless stalled, otherwise the FIFO head.
  always_comb begin
    grant = GNT_NONE;
    if (a_valid && !a_stall_q) begin
      grant = GNT_A;
    end else if (!fifo_empty) begin
      grant = GNT_B;
    end
  end

  // Next registered write; address 0 is never written but its grant still consumes the slot.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (grant)
      GNT_A: begin
        if (a_addr != '0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = a_addr;
          rf_wdata_d = a_data;
        end
      end
      GNT_B: begin
        if (head_addr != '0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = head_addr;
          rf_wdata_d = head_data;
        end
      end
      default: ;
    endcase
  end

  // Starvation counter and A throttle; a head pop always releases the stall.
  always_comb begin
    starve_d  = starve_q;
    a_stall_d = a_stall_q;
    err_a_d   = err_a_q || (a_valid && a_stall_q);
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
    if (fifo_pop) begin
      a_stall_d = 1'b0;
    end else if (starve_d == STARVE_W'(STARVE_LIM)) begin
      a_stall_d = 1'b1;
    end
  end

  // Busy scoreboard: clear on B head grant, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (iss_valid && (iss_addr != '0)) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      starve_q   <= '0;
      a_stall_q  <= 1'b0;
      err_a_q    <= 1'b0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      starve_q   <= starve_d;
      a_stall_q  <= a_stall_d;
      err_a_q    <= err_a_d;
      busy_q     <= busy_d;
    end
  end

  // Upstream must never present an A request while a_stall is high.
  a_protocol_ok: assert property (@(posedge clk) disable iff (rst) !err_a_q);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected writes are queued with the
// cycle they must appear in and compared as the register-file port fires.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hz_rs;
  logic        hz_rt;
  logic [31:0] busy_vec;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  rf_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_stall  (a_stall),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .hz_rs    (hz_rs),
    .hz_rt    (hz_rt),
    .busy_vec (busy_vec),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  typedef struct {
    int unsigned due;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        aq[$];
  exp_t        bq[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock, then compare the register-file port against the scoreboard.
  task automatic step();
    exp_t e;
    logic due_now;
    @(posedge clk);
    #1;
    cyc++;
    due_now = 1'b0;
    if (aq.size() > 0 && aq[0].due == cyc) begin
      e = aq.pop_front();
      due_now = 1'b1;
    end else if (bq.size() > 0 && bq[0].due == cyc) begin
      e = bq.pop_front();
      due_now = 1'b1;
    end
    check("rf_we", {31'd0, rf_we}, {31'd0, due_now});
    if (due_now && rf_we) begin
      check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
      check("rf_wdata", rf_wdata, e.data);
    end
  endtask

  task automatic idle_inputs();
    a_valid   = 1'b0;
    a_addr    = '0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_addr    = '0;
    b_data    = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  // A write is expected on the port the cycle after it is driven.
  task automatic drive_a(input logic [4:0] addr, input logic [31:0] data);
    a_valid = 1'b1;
    a_addr  = addr;
    a_data  = data;
    if (addr != 5'd0) aq.push_back('{cyc + 1, addr, data});
  endtask

  // due == 0 marks a beat that must never reach the port.
  task automatic drive_b(input logic [4:0] addr, input logic [31:0] data, input int unsigned due);
    b_valid = 1'b1;
    b_addr  = addr;
    b_data  = data;
    if (addr != 5'd0 && due != 0) bq.push_back('{due, addr, data});
  endtask

  initial begin
    int unsigned k0;
    idle_inputs();
    rs_addr = '0;
    rt_addr = '0;
    rst     = 1'b1;

    // Reset state
    step();
    step();
    check("rst_busy", busy_vec, 32'h0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd1);
    check("rst_a_stall", {31'd0, a_stall}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    rst = 1'b0;
    step();

    // A-only writes, first the canonical one then back-to-back patterns
    drive_a(5'd3, 32'h11);
    step();
    for (int i = 0; i < 4; i++) begin
      drive_a(5'(1 + $urandom_range(30)), $urandom);
      step();
    end
    idle_inputs();
    step();
    check("a_busy_unchanged", busy_vec, 32'h0);

    // Issue to r5, B result three cycles later; issue to r0 is ignored
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    step();
    iss_addr  = 5'd0;
    rs_addr   = 5'd5;
    rt_addr   = 5'd6;
    #1;
    check("busy5_set", busy_vec, 32'h20);
    check("hz_rs_5", {31'd0, hz_rs}, 32'd1);
    check("hz_rt_6", {31'd0, hz_rt}, 32'd0);
    step();
    iss_valid = 1'b0;
    rs_addr   = 5'd0;
    #1;
    check("busy0_never", busy_vec, 32'h20);
    check("hz_rs_0", {31'd0, hz_rs}, 32'd0);
    step();
    drive_b(5'd5, 32'hABCD, cyc + 2);
    step();
    idle_inputs();
    check("busy5_pending", busy_vec, 32'h20);
    step();
    rs_addr = 5'd5;
    #1;
    check("busy5_clear", busy_vec, 32'h0);
    check("hz_rs_5_clear", {31'd0, hz_rs}, 32'd0);
    step();

    // A every cycle starves two B beats until a_stall throttles A
    k0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive_a(5'(8 + i), 32'hA300 + 32'(i));
      if (i == 0) drive_b(5'd20, 32'hB001, k0 + 9);
      else if (i == 1) drive_b(5'd21, 32'hB002, k0 + 10);
      else begin
        b_valid = 1'b0;
        check("b_ready_full", {31'd0, b_ready}, 32'd0);
      end
      check("a_stall_low", {31'd0, a_stall}, 32'd0);
      step();
    end
    idle_inputs();
    check("a_stall_high", {31'd0, a_stall}, 32'd1);
    check("b_ready_still_full", {31'd0, b_ready}, 32'd0);
    step();
    check("a_stall_drop", {31'd0, a_stall}, 32'd0);
    check("b_ready_after_pop", {31'd0, b_ready}, 32'd1);
    step();
    step();

    // Address-0 writes from both sources are suppressed but the FIFO still drains
    drive_a(5'd0, 32'hDEAD);
    drive_b(5'd0, 32'hBEEF, 0);
    step();
    idle_inputs();
    drive_b(5'd10, 32'h1010, cyc + 2);
    step();
    drive_b(5'd11, 32'h1111, cyc + 2);
    step();
    idle_inputs();
    step();
    step();
    check("zero_busy", busy_vec, 32'h0);

    // Same-cycle issue and head grant on r7: set wins; same-register beats stay ordered
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    step();
    iss_valid = 1'b0;
    rt_addr   = 5'd7;
    #1;
    check("busy7_set", busy_vec, 32'h80);
    check("hz_rt_7", {31'd0, hz_rt}, 32'd1);
    drive_b(5'd7, 32'h7000, cyc + 2);
    step();
    b_valid   = 1'b0;
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    step();
    iss_valid = 1'b0;
    check("busy7_set_wins", busy_vec, 32'h80);
    drive_b(5'd7, 32'h0071, cyc + 2);
    step();
    drive_b(5'd7, 32'h0072, cyc + 2);
    step();
    idle_inputs();
    check("busy7_clear", busy_vec, 32'h0);
    step();
    step();

    // Reset with a full FIFO and r5/r7 pending discards everything
    drive_a(5'd1, 32'h0101);
    drive_b(5'd5, 32'h5555, 0);
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    step();
    drive_a(5'd2, 32'h0202);
    drive_b(5'd7, 32'h7777, 0);
    iss_addr = 5'd7;
    step();
    check("pre_rst_busy", busy_vec, 32'hA0);
    check("pre_rst_full", {31'd0, b_ready}, 32'd0);
    rst       = 1'b1;
    a_valid   = 1'b1;
    a_addr    = 5'd3;
    a_data    = 32'h0303;
    b_valid   = 1'b1;
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    step();
    rst = 1'b0;
    idle_inputs();
    check("post_rst_busy", busy_vec, 32'h0);
    check("post_rst_b_ready", {31'd0, b_ready}, 32'd1);
    check("post_rst_a_stall", {31'd0, a_stall}, 32'd0);
    check("post_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("post_rst_wdata", rf_wdata, 32'd0);
    for (int i = 0; i < 4; i++) step();

    check("a_queue_drained", aq.size(), 32'd0);
    check("b_queue_drained", bq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
